// File: rtl/gb_read_arbiter.sv
// gb_read_arbiter: shares the two global_buffer read ports among NUM_REQ
// requesters. Grants up to two bank-disjoint reads per cycle, round-robin,
// and routes each returned word to its issuer using a fixed-latency tag pipe.
// Optional statistics counters are enabled by defining GB_ARB_STATS_EN.
module gb_read_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned RD_LAT     = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [ADDR_WIDTH-1:0]            gb_raddr_a,
    output logic [ADDR_WIDTH-1:0]            gb_raddr_b,
    input  logic [DATA_WIDTH-1:0]            gb_dout_a,
    input  logic [DATA_WIDTH-1:0]            gb_dout_b,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data
`ifdef GB_ARB_STATS_EN
    ,
    output logic [31:0]                      stat_grants,
    output logic [31:0]                      stat_conflicts
`endif
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic           va;
        logic [IDW-1:0] ia;
        logic           vb;
        logic [IDW-1:0] ib;
    } tag_t;

    // Bank map: top address bit selects OUTPUT, next bit WEIGHT, else INPUT.
    function automatic logic [1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        if (a[ADDR_WIDTH-1])      return 2'd2;
        else if (a[ADDR_WIDTH-2]) return 2'd1;
        else                      return 2'd0;
    endfunction

    function automatic int unsigned wrap_id(input int unsigned base, input int unsigned k);
        return (base + k) % NUM_REQ;
    endfunction

    logic [IDW-1:0]        rr_ptr;
    logic                  gnt_a, gnt_b, clash;
    logic [IDW-1:0]        id_a, id_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic [1:0]            bank_a;
    tag_t                  tag_q [RD_LAT+1];

    // Round-robin pick for port A, then first later requester on another bank for B.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        clash     = 1'b0;
        id_a      = '0;
        id_b      = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!rst && !gnt_a && req_valid[wrap_id(32'(rr_ptr), k)]) begin
                gnt_a = 1'b1;
                id_a  = IDW'(wrap_id(32'(rr_ptr), k));
            end
        end
        addr_a = req_addr[id_a*ADDR_WIDTH +: ADDR_WIDTH];
        bank_a = bank_of(addr_a);
        for (int unsigned k = 1; k < NUM_REQ; k++) begin
            if (gnt_a && !gnt_b && req_valid[wrap_id(32'(id_a), k)]) begin
                if (bank_of(req_addr[wrap_id(32'(id_a), k)*ADDR_WIDTH +: ADDR_WIDTH]) != bank_a) begin
                    gnt_b = 1'b1;
                    id_b  = IDW'(wrap_id(32'(id_a), k));
                end else begin
                    clash = 1'b1;
                end
            end
        end
        addr_b = req_addr[id_b*ADDR_WIDTH +: ADDR_WIDTH];
        if (gnt_a) req_ready[id_a] = 1'b1;
        if (gnt_b) req_ready[id_b] = 1'b1;
    end

    // Pointer advance and read-address registers; an idle port shadows the active one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            gb_raddr_a <= '0;
            gb_raddr_b <= '0;
        end else begin
            if (gnt_a) rr_ptr <= IDW'(wrap_id(32'(id_a), 1));
            gb_raddr_a <= gnt_a ? addr_a : '0;
            gb_raddr_b <= gnt_b ? addr_b : (gnt_a ? addr_a : '0);
        end
    end

    // Tag pipeline aligned so the last stage coincides with dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{va: gnt_a, ia: id_a, vb: gnt_b, ib: id_b};
            for (int unsigned i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Capture returned words into the issuing requester's slot and pulse its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (tag_q[RD_LAT].va) begin
                rsp_valid[tag_q[RD_LAT].ia] <= 1'b1;
                rsp_data[tag_q[RD_LAT].ia*DATA_WIDTH +: DATA_WIDTH] <= gb_dout_a;
            end
            if (tag_q[RD_LAT].vb) begin
                rsp_valid[tag_q[RD_LAT].ib] <= 1'b1;
                rsp_data[tag_q[RD_LAT].ib*DATA_WIDTH +: DATA_WIDTH] <= gb_dout_b;
            end
        end
    end

`ifdef GB_ARB_STATS_EN
    logic [31:0] grant_inc;
    assign grant_inc = gnt_b ? 32'd2 : (gnt_a ? 32'd1 : 32'd0);

    // Saturating grant and bank-clash counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            stat_grants <= (stat_grants > ('1 - grant_inc)) ? '1 : stat_grants + grant_inc;
            if (clash && stat_conflicts != '1) stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gb_read_arbiter.sv
// Directed bench for gb_read_arbiter: table of single-cycle grant vectors plus
// hand-written latency, fairness and reset-flush sequences.
module tb_gb_read_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid;
    logic [47:0]  req_addr;
    logic [2:0]   req_ready;
    logic [15:0]  gb_raddr_a, gb_raddr_b;
    logic [127:0] gb_dout_a, gb_dout_b;
    logic [2:0]   rsp_valid;
    logic [383:0] rsp_data;
`ifdef GB_ARB_STATS_EN
    logic [31:0]  stat_grants, stat_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gb_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(128), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .gb_raddr_a(gb_raddr_a), .gb_raddr_b(gb_raddr_b),
        .gb_dout_a(gb_dout_a), .gb_dout_b(gb_dout_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef GB_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
    );

    // Global buffer stand-in: data is a function of the address, 3 cycles after raddr.
    function automatic logic [127:0] mk(input logic [15:0] a);
        return {a, ~a, a ^ 16'h1234, a + 16'h0101, 64'h0123_4567_89AB_CDEF};
    endfunction

    logic [15:0] pa [3];
    logic [15:0] pb [3];
    // Read-latency delay line of the memory model.
    always @(posedge clk) begin
        pa[0] <= gb_raddr_a; pa[1] <= pa[0]; pa[2] <= pa[1];
        pb[0] <= gb_raddr_b; pb[1] <= pb[0]; pb[2] <= pb[1];
    end
    assign gb_dout_a = mk(pa[2]);
    assign gb_dout_b = mk(pb[2]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] v, input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(3'b111, 16'h0001, 16'h4001, 16'h8001);
        step();
        check("ready_in_reset", 128'(req_ready), 128'(3'b000));
        step();
        rst = 1'b0;
        set_req(3'b000, 16'h0, 16'h0, 16'h0);
        check("reset_raddr_a", 128'(gb_raddr_a), 128'h0);
        check("reset_raddr_b", 128'(gb_raddr_b), 128'h0);
        check("reset_rsp_valid", 128'(rsp_valid), 128'h0);
`ifdef GB_ARB_STATS_EN
        check("reset_stat_grants", 128'(stat_grants), 128'h0);
`endif
    endtask

    typedef struct {
        string       name;
        logic [2:0]  v;
        logic [15:0] a0, a1, a2;
        logic [2:0]  rdy;
        logic [15:0] ra, rb;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;

        // Each vector starts from reset, so rr_ptr = 0.
        tbl[0] = '{"single_input",   3'b001, 16'h0010, 16'h0000, 16'h0000, 3'b001, 16'h0010, 16'h0010};
        tbl[1] = '{"dual_in_wt",     3'b011, 16'h0001, 16'h4002, 16'h0000, 3'b011, 16'h0001, 16'h4002};
        tbl[2] = '{"clash_input",    3'b011, 16'h0001, 16'h0003, 16'h0000, 3'b001, 16'h0001, 16'h0001};
        tbl[3] = '{"clash_output",   3'b011, 16'h8000, 16'hC004, 16'h0000, 3'b001, 16'h8000, 16'h8000};
        tbl[4] = '{"skip_to_req2",   3'b111, 16'h8000, 16'hC004, 16'h4000, 3'b101, 16'h8000, 16'h4000};
        tbl[5] = '{"all_idle",       3'b000, 16'h1234, 16'h4321, 16'h8888, 3'b000, 16'h0000, 16'h0000};
        tbl[6] = '{"a_req1_b_req2",  3'b110, 16'h0000, 16'h4000, 16'h0005, 3'b110, 16'h4000, 16'h0005};
        tbl[7] = '{"only_req2",      3'b100, 16'h0000, 16'h0000, 16'hFFFF, 3'b100, 16'hFFFF, 16'hFFFF};
        tbl[8] = '{"clash_weight",   3'b101, 16'h4000, 16'h0000, 16'h4001, 3'b001, 16'h4000, 16'h4000};

        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_req(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2);
            #1;
            check({tbl[i].name, "_ready"}, 128'(req_ready), 128'(tbl[i].rdy));
            step();
            set_req(3'b000, 16'h0, 16'h0, 16'h0);
            check({tbl[i].name, "_raddr_a"}, 128'(gb_raddr_a), 128'(tbl[i].ra));
            check({tbl[i].name, "_raddr_b"}, 128'(gb_raddr_b), 128'(tbl[i].rb));
        end

        // Single read: response five cycles after the handshake, data then held.
        do_reset();
        set_req(3'b001, 16'h0010, 16'h0, 16'h0);
        step();
        set_req(3'b000, 16'h0, 16'h0, 16'h0);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("lat1_valid_k%0d", k), 128'(rsp_valid), 128'((k == 5) ? 3'b001 : 3'b000));
            if (k >= 5) check($sformatf("lat1_data_k%0d", k), rsp_data[127:0], mk(16'h0010));
            step();
        end

        // Dual grant: both words return together to the right requesters.
        do_reset();
        set_req(3'b011, 16'h0001, 16'h4002, 16'h0);
        step();
        set_req(3'b000, 16'h0, 16'h0, 16'h0);
        repeat (3) step();
        check("dual_early_valid", 128'(rsp_valid), 128'h0);
        step();
        check("dual_valid", 128'(rsp_valid), 128'(3'b011));
        check("dual_data0", rsp_data[127:0], mk(16'h0001));
        check("dual_data1", rsp_data[255:128], mk(16'h4002));

        // Same-bank pair: req0 first, then req1 after req0 drops.
        do_reset();
        set_req(3'b011, 16'h0001, 16'h0003, 16'h0);
        #1;
        check("clash_c0_ready", 128'(req_ready), 128'(3'b001));
        step();
        set_req(3'b010, 16'h0001, 16'h0003, 16'h0);
        #1;
        check("clash_c1_ready", 128'(req_ready), 128'(3'b010));
        step();
        set_req(3'b000, 16'h0, 16'h0, 16'h0);
        check("clash_c1_raddr_a", 128'(gb_raddr_a), 128'h0003);
`ifdef GB_ARB_STATS_EN
        check("stat_grants", 128'(stat_grants), 128'd2);
        check("stat_conflicts", 128'(stat_conflicts), 128'd1);
`endif

        // Three same-bank requesters held: grants rotate 0,1,2,0,1,2.
        do_reset();
        set_req(3'b111, 16'h0000, 16'h0001, 16'h0002);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_ready_%0d", i), 128'(req_ready), 128'(3'b001 << (i % 3)));
            step();
            check($sformatf("rr_raddr_%0d", i), 128'(gb_raddr_a), 128'(i % 3));
        end
        set_req(3'b000, 16'h0, 16'h0, 16'h0);

        // Reset with four reads in flight: nothing comes back afterwards.
        do_reset();
        set_req(3'b011, 16'h0001, 16'h4002, 16'h0);
        step();
        step();
        set_req(3'b000, 16'h0, 16'h0, 16'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("flush_rsp_data", rsp_data[255:0], 128'h0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("flush_valid_%0d", k), 128'(rsp_valid), 128'h0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
